ps2_kbd_decode: RTL and testbench

- Downstream consumer of the PS/2 receive block. Pops raw Scan Code Set 2 bytes from that block's byte FIFO and tracks the E0, F0 and E1 prefixes.
- Maintains modifier state and translates make codes to ASCII or cursor codes.
- Queues decoded keys in a small output FIFO that the CPU bus reads with a valid/ready handshake.

---
 rtl/ps2_kbd_pkg.sv | 66 ++++++
 rtl/ps2_kbd_decode_keymap.sv | 79 +++++++
 rtl/ps2_kbd_decode.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_kbd_decode.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared FSM states, scancode constants, modifier bit positions and the output FIFO entry layout.
// The entry gains raw code and break flag fields when PS2KBD_RAW_EN is defined.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DECODE, S_EMIT} state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SLASH  = 8'h4A;

  localparam logic [7:0] CUR_UP    = 8'h80;
  localparam logic [7:0] CUR_DOWN  = 8'h81;
  localparam logic [7:0] CUR_LEFT  = 8'h82;
  localparam logic [7:0] CUR_RIGHT = 8'h83;

  localparam int MOD_CAPS  = 0;
  localparam int MOD_SHIFT = 1;
  localparam int MOD_CTRL  = 2;
  localparam int MOD_ALT   = 3;

  typedef struct packed {
    logic [7:0] ascii;
    logic [3:0] mods;
    logic       ext;
`ifdef PS2KBD_RAW_EN
    logic [7:0] raw;
    logic       brk;
`endif
  } key_ent_t;

  // BAT, ack, echo, resend and error bytes carry no key information.
  function automatic logic is_special(input logic [7:0] b);
    return b inside {BYTE_AA, BYTE_FA, BYTE_EE, BYTE_FE, BYTE_00, BYTE_FF};
  endfunction

  function automatic logic [3:0] pack_mods(input logic alt, input logic ctrl,
                                           input logic shift, input logic caps);
    logic [3:0] m;
    m            = '0;
    m[MOD_ALT]   = alt;
    m[MOD_CTRL]  = ctrl;
    m[MOD_SHIFT] = shift;
    m[MOD_CAPS]  = caps;
    return m;
  endfunction

endpackage

// File: rtl/ps2_kbd_decode_keymap.sv
// Combinational set-2 keymap: scancode plus modifiers to ASCII or cursor code, 0 when unmapped.
// Zero latency; no handshake.
module ps2_kbd_decode_keymap
  import ps2_kbd_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  input  logic       i_ctrl,
  output logic [7:0] o_ascii
);

  logic [15:0] w_pair;
  logic [7:0]  w_lo;
  logic [7:0]  w_hi;
  logic [7:0]  w_up;
  logic        w_letter;

  // Each entry holds {unshifted, shifted} glyphs.
  always_comb begin
    w_pair = 16'h0000;
    case (i_code)
      8'h1C: w_pair = "aA";  8'h32: w_pair = "bB";  8'h21: w_pair = "cC";
      8'h23: w_pair = "dD";  8'h24: w_pair = "eE";  8'h2B: w_pair = "fF";
      8'h34: w_pair = "gG";  8'h33: w_pair = "hH";  8'h43: w_pair = "iI";
      8'h3B: w_pair = "jJ";  8'h42: w_pair = "kK";  8'h4B: w_pair = "lL";
      8'h3A: w_pair = "mM";  8'h31: w_pair = "nN";  8'h44: w_pair = "oO";
      8'h4D: w_pair = "pP";  8'h15: w_pair = "qQ";  8'h2D: w_pair = "rR";
      8'h1B: w_pair = "sS";  8'h2C: w_pair = "tT";  8'h3C: w_pair = "uU";
      8'h2A: w_pair = "vV";  8'h1D: w_pair = "wW";  8'h22: w_pair = "xX";
      8'h35: w_pair = "yY";  8'h1A: w_pair = "zZ";
      8'h45: w_pair = "0)";  8'h16: w_pair = "1!";  8'h1E: w_pair = "2@";
      8'h26: w_pair = "3#";  8'h25: w_pair = "4$";  8'h2E: w_pair = "5%";
      8'h36: w_pair = "6^";  8'h3D: w_pair = "7&";  8'h3E: w_pair = "8*";
      8'h46: w_pair = "9(";
      8'h0E: w_pair = "`~";  8'h4E: w_pair = "-_";  8'h55: w_pair = "=+";
      8'h5D: w_pair = {8'h5C, 8'h7C};
      8'h54: w_pair = "[{";  8'h5B: w_pair = "]}";
      8'h4C: w_pair = ";:";
      8'h52: w_pair = {8'h27, 8'h22};
      8'h41: w_pair = ",<";
      8'h49: w_pair = ".>";  8'h4A: w_pair = "/?";  8'h29: w_pair = "  ";
      8'h5A: w_pair = 16'h0D0D;
      8'h66: w_pair = 16'h0808;
      8'h0D: w_pair = 16'h0909;
      8'h76: w_pair = 16'h1B1B;
      default: w_pair = 16'h0000;
    endcase
  end

  assign w_lo     = w_pair[15:8];
  assign w_hi     = w_pair[7:0];
  assign w_letter = (w_lo >= "a") && (w_lo <= "z");
  assign w_up     = w_lo - 8'h20;

  always_comb begin
    o_ascii = 8'h00;
    if (i_ext) begin
      case (i_code)
        SC_UP:    o_ascii = CUR_UP;
        SC_DOWN:  o_ascii = CUR_DOWN;
        SC_LEFT:  o_ascii = CUR_LEFT;
        SC_RIGHT: o_ascii = CUR_RIGHT;
        SC_ENTER: o_ascii = 8'h0D;
        SC_SLASH: o_ascii = "/";
        default:  o_ascii = 8'h00;
      endcase
    end else if (w_letter) begin
      if (i_ctrl)
        o_ascii = w_up & 8'h1F;
      else
        o_ascii = (i_shift ^ i_caps) ? w_up : w_lo;
    end else begin
      o_ascii = i_shift ? w_hi : w_lo;
    end
  end

endmodule

// File: rtl/ps2_kbd_decode.sv
// PS/2 set-2 decoder: pops upstream bytes, tracks E0/F0/E1 prefixes and modifiers, queues keys (PS2KBD_RAW_EN: emit every key code).
// Latency: 4 cycles from upstream pop to key_valid; at most one byte per 3 cycles.
// Backpressure: key_ready pops the output FIFO; a key arriving to a full FIFO is dropped and flags key_overflow.
module ps2_kbd_decode
  import ps2_kbd_pkg::*;
#(
  parameter int OFIFO_AW   = 3,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_rdata,
  input  logic       ps2_dr,
  output logic       ps2_rstrb,
  output logic       key_valid,
  output logic [7:0] key_ascii,
  output logic [3:0] key_mods,
  output logic [7:0] key_raw,
  output logic       key_break,
  output logic       key_ext,
  input  logic       key_ready,
  output logic       key_overflow,
  output logic [3:0] mods
);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0] r_byte;
  logic [7:0] r_skip;
  logic       r_ext;
  logic       r_brk;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_ctrl;
  logic       r_alt;
  logic       r_caps;
  key_ent_t   r_ent;

  key_ent_t              r_mem [2**OFIFO_AW];
  logic [OFIFO_AW-1:0]   r_wptr;
  logic [OFIFO_AW-1:0]   r_rptr;
  logic                  r_ovf;

  logic       w_rstrb;
  logic       w_skipping;
  logic       w_is_key;
  logic       w_lshift_n;
  logic       w_rshift_n;
  logic       w_ctrl_n;
  logic       w_alt_n;
  logic       w_caps_n;
  logic [3:0] w_mods_n;
  logic [7:0] w_map;
  logic       w_gen;
  key_ent_t   w_ent;
  key_ent_t   w_head;
  logic       w_pop;
  logic       w_full;
  logic       w_wr;
  logic       w_drop;

  assign w_skipping = (r_skip != 8'd0);
  assign w_is_key   = !w_skipping && !(r_byte inside {BYTE_E0, BYTE_E1, BYTE_F0}) &&
                      !is_special(r_byte);

  // Next modifier state: the entry for this key sees its own effect.
  always_comb begin
    w_lshift_n = r_lshift;
    w_rshift_n = r_rshift;
    w_ctrl_n   = r_ctrl;
    w_alt_n    = r_alt;
    w_caps_n   = r_caps;
    if (w_is_key) begin
      if (!r_ext && r_byte == SC_LSHIFT) w_lshift_n = !r_brk;
      if (!r_ext && r_byte == SC_RSHIFT) w_rshift_n = !r_brk;
      if (r_byte == SC_CTRL)             w_ctrl_n   = !r_brk;
      if (r_byte == SC_ALT)              w_alt_n    = !r_brk;
      if (!r_ext && r_byte == SC_CAPS && !r_brk) w_caps_n = !r_caps;
    end
  end

  assign w_mods_n = pack_mods(w_alt_n, w_ctrl_n, w_lshift_n | w_rshift_n, w_caps_n);

  ps2_kbd_decode_keymap u_keymap (
    .i_ext   (r_ext),
    .i_code  (r_byte),
    .i_shift (w_mods_n[MOD_SHIFT]),
    .i_caps  (w_mods_n[MOD_CAPS]),
    .i_ctrl  (w_mods_n[MOD_CTRL]),
    .o_ascii (w_map)
  );

  always_comb begin
    w_ent      = '0;
    w_ent.mods = w_mods_n;
    w_ent.ext  = r_ext;
`ifdef PS2KBD_RAW_EN
    w_ent.ascii = r_brk ? 8'h00 : w_map;
    w_ent.raw   = r_byte;
    w_ent.brk   = r_brk;
    w_gen       = w_is_key;
`else
    w_ent.ascii = w_map;
    w_gen       = w_is_key && !r_brk && (w_map != 8'h00);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rstrb     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ps2_dr) begin
          w_rstrb     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:   w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_gen ? S_EMIT : S_IDLE;
      S_EMIT:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte   <= 8'h00;
      r_skip   <= 8'd0;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_ctrl   <= 1'b0;
      r_alt    <= 1'b0;
      r_caps   <= 1'b0;
      r_ent    <= '0;
    end else begin
      if (w_rstrb) r_byte <= ps2_rdata;
      if (r_state == S_DECODE) begin
        if (w_skipping)               r_skip <= r_skip - 8'd1;
        else if (r_byte == BYTE_E1)   r_skip <= 8'(PAUSE_SKIP);
        else if (r_byte == BYTE_E0)   r_ext  <= 1'b1;
        else if (r_byte == BYTE_F0)   r_brk  <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
        r_lshift <= w_lshift_n;
        r_rshift <= w_rshift_n;
        r_ctrl   <= w_ctrl_n;
        r_alt    <= w_alt_n;
        r_caps   <= w_caps_n;
        if (w_gen) r_ent <= w_ent;
      end
    end
  end

  // One slot stays empty so full and empty are distinguishable; a pop makes room for a same-cycle write.
  assign w_pop  = key_valid && key_ready;
  assign w_full = ((r_wptr + OFIFO_AW'(1)) == r_rptr);
  assign w_wr   = (r_state == S_EMIT) && (!w_full || w_pop);
  assign w_drop = (r_state == S_EMIT) && !w_wr;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_ent;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)   r_wptr <= r_wptr + OFIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + OFIFO_AW'(1);
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_pop) r_ovf <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign ps2_rstrb    = w_rstrb;
  assign key_valid    = (r_wptr != r_rptr);
  assign key_ascii    = w_head.ascii;
  assign key_mods     = w_head.mods;
  assign key_ext      = w_head.ext;
  assign key_overflow = r_ovf;
  assign mods         = pack_mods(r_alt, r_ctrl, r_lshift | r_rshift, r_caps);

`ifdef PS2KBD_RAW_EN
  assign key_raw   = w_head.raw;
  assign key_break = w_head.brk;
`else
  assign key_raw   = 8'h00;
  assign key_break = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_decode.sv
// Scoreboard bench for ps2_kbd_decode: table-driven keyboard model predicts entries, a monitor checks each pop.
module tb_ps2_kbd_decode;

  localparam int AW  = 3;
  localparam int CAP = (1 << AW) - 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_rdata = 8'h00;
  logic       ps2_dr = 1'b0;
  logic       ps2_rstrb;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic [3:0] key_mods;
  logic [7:0] key_raw;
  logic       key_break;
  logic       key_ext;
  logic       key_ready = 1'b0;
  logic       key_overflow;
  logic [3:0] dut_mods;

  ps2_kbd_decode #(.OFIFO_AW(AW), .PAUSE_SKIP(7)) dut (
    .clk(clk), .resetn(resetn), .ps2_rdata(ps2_rdata), .ps2_dr(ps2_dr), .ps2_rstrb(ps2_rstrb),
    .key_valid(key_valid), .key_ascii(key_ascii), .key_mods(key_mods), .key_raw(key_raw),
    .key_break(key_break), .key_ext(key_ext), .key_ready(key_ready),
    .key_overflow(key_overflow), .mods(dut_mods)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] ascii; logic [3:0] mods; logic ext; } ent_t;

  ent_t       exp_q[$];
  ent_t       got_q[$];
  logic [7:0] up_q[$];
  logic [7:0] lo_tab[int];
  logic [7:0] hi_tab[int];
  logic [7:0] ext_tab[int];
  int         key_codes[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         rdy_mode = 1;
  int         pop_budget = 0;

  bit m_ext, m_brk, m_lsh, m_rsh, m_ctrl, m_alt, m_caps, m_ovf;
  int m_skip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] model_mods();
    return {m_alt, m_ctrl, m_lsh | m_rsh, m_caps};
  endfunction

  function automatic logic [7:0] ref_ascii(input bit ext, input logic [7:0] code,
                                           input bit sh, input bit cp, input bit ct);
    logic [7:0] lo;
    logic [7:0] up;
    if (ext) return ext_tab.exists(int'(code)) ? ext_tab[int'(code)] : 8'h00;
    if (!lo_tab.exists(int'(code))) return 8'h00;
    lo = lo_tab[int'(code)];
    if (lo >= "a" && lo <= "z") begin
      up = lo - 8'h20;
      if (ct) return up & 8'h1F;
      return (sh ^ cp) ? up : lo;
    end
    return sh ? hi_tab[int'(code)] : lo;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    bit         mk;
    logic [7:0] a;
    ent_t       e;
    if (m_skip != 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      mk = !m_brk;
      if (!m_ext && b == 8'h12) m_lsh = mk;
      if (!m_ext && b == 8'h59) m_rsh = mk;
      if (b == 8'h14) m_ctrl = mk;
      if (b == 8'h11) m_alt = mk;
      if (!m_ext && b == 8'h58 && mk) m_caps = !m_caps;
      a = ref_ascii(m_ext, b, m_lsh | m_rsh, m_caps, m_ctrl);
      if (mk && a != 8'h00) begin
        if (rdy_mode == 0 && exp_q.size() >= CAP) m_ovf = 1;
        else begin
          e.ascii = a;
          e.mods  = model_mods();
          e.ext   = m_ext;
          exp_q.push_back(e);
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    up_q.push_back(b);
  endtask

  task automatic tap(input logic [7:0] c, input bit ext);
    if (ext) send(8'hE0);
    send(c);
    if (ext) send(8'hE0);
    send(8'hF0);
    send(c);
  endtask

  // Upstream byte FIFO model plus key_ready driver, both updated just after the rising edge.
  always begin : upstream
    logic       took;
    logic [7:0] dropped;
    @(negedge clk);
    took = ps2_rstrb && ps2_dr;
    @(posedge clk);
    #1;
    if (took && up_q.size() != 0) dropped = up_q.pop_front();
    ps2_dr    = (up_q.size() != 0);
    ps2_rdata = (up_q.size() != 0) ? up_q[0] : 8'h00;
    case (rdy_mode)
      0: begin
        key_ready = (pop_budget > 0);
        if (pop_budget > 0) pop_budget--;
      end
      1:       key_ready = 1'b1;
      default: key_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin : monitor
    ent_t e;
    ent_t g;
    if (resetn && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_key: got ascii 0x%0h, expected no entry", key_ascii);
      end else begin
        e = exp_q.pop_front();
        chk("key_ascii", 32'(key_ascii), 32'(e.ascii));
        chk("key_mods", 32'(key_mods), 32'(e.mods));
        chk("key_ext", 32'(key_ext), 32'(e.ext));
        chk("key_raw", 32'(key_raw), 32'(0));
        chk("key_break", 32'(key_break), 32'(0));
      end
      g.ascii = key_ascii;
      g.mods  = key_mods;
      g.ext   = key_ext;
      got_q.push_back(g);
      m_ovf = 0;
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0; m_caps = 0;
    m_ovf = 0; m_skip = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_key_valid", 32'(key_valid), 32'(0));
    chk("rst_overflow", 32'(key_overflow), 32'(0));
    chk("rst_mods", 32'(dut_mods), 32'(0));
    chk("rst_rstrb", 32'(ps2_rstrb), 32'(0));
    resetn = 1'b1;
  endtask

  task automatic wait_up();
    int n = 0;
    while (up_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("upstream_drained", 32'(up_q.size()), 32'(0));
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("drained", 32'(up_q.size() + exp_q.size()), 32'(0));
  endtask

  task automatic chk_got(input string name, input int idx, input logic [7:0] asc, input logic ext);
    if (got_q.size() > idx) begin
      chk({name, "_ascii"}, 32'(got_q[idx].ascii), 32'(asc));
      chk({name, "_ext"}, 32'(got_q[idx].ext), 32'(ext));
    end
  endtask

  task automatic rand_event();
    int r;
    int c;
    logic [7:0] ext_keys[8];
    ext_keys = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h4A, 8'h7D, 8'h70};
    r = $urandom_range(0, 99);
    c = key_codes[$urandom_range(0, key_codes.size() - 1)];
    if (r < 45) tap(8'(c), 0);
    else if (r < 55) begin
      c = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      send(8'(c));
      repeat ($urandom_range(1, 3)) tap(8'(key_codes[$urandom_range(0, key_codes.size() - 1)]), 0);
      send(8'hF0);
      send(8'(c));
    end else if (r < 62) tap(8'h58, 0);
    else if (r < 76) begin
      c = (r < 70) ? 8'h14 : 8'h11;
      if (r % 2 == 0) send(8'hE0);
      send(8'(c));
      repeat ($urandom_range(1, 2)) tap(8'(key_codes[$urandom_range(0, key_codes.size() - 1)]), 0);
      if (r % 2 == 0) send(8'hE0);
      send(8'hF0);
      send(8'(c));
    end else if (r < 88) tap(ext_keys[$urandom_range(0, 7)], 1);
    else if (r < 94) begin
      logic [7:0] sp[6];
      sp = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
      send(sp[$urandom_range(0, 5)]);
    end else if (r < 97) begin
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    end else send(8'($urandom_range(0, 255)));
  endtask

  initial begin : build_tables
    string      s_let, s_dlo, s_dhi;
    logic [7:0] pun_lo[12];
    logic [7:0] pun_hi[12];
    logic [7:0] let_codes[26];
    logic [7:0] dig_codes[10];
    logic [7:0] pun_codes[12];
    logic [7:0] ctl_codes[4];
    logic [7:0] ctl_vals[4];
    s_let = "abcdefghijklmnopqrstuvwxyz";
    s_dlo = "0123456789";
    s_dhi = ")!@#$%^&*(";
    pun_lo = '{8'h60, 8'h2D, 8'h3D, 8'h5C, 8'h5B, 8'h5D, 8'h3B, 8'h27, 8'h2C, 8'h2E,
               8'h2F, 8'h20};
    pun_hi = '{8'h7E, 8'h5F, 8'h2B, 8'h7C, 8'h7B, 8'h7D, 8'h3A, 8'h22, 8'h3C, 8'h3E,
               8'h3F, 8'h20};
    let_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                  8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                  8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    dig_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    pun_codes = '{8'h0E, 8'h4E, 8'h55, 8'h5D, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49,
                  8'h4A, 8'h29};
    ctl_codes = '{8'h5A, 8'h66, 8'h0D, 8'h76};
    ctl_vals  = '{8'h0D, 8'h08, 8'h09, 8'h1B};
    for (int i = 0; i < 26; i++) begin
      lo_tab[int'(let_codes[i])] = s_let[i];
      hi_tab[int'(let_codes[i])] = s_let[i] - 8'h20;
      key_codes.push_back(int'(let_codes[i]));
    end
    for (int i = 0; i < 10; i++) begin
      lo_tab[int'(dig_codes[i])] = s_dlo[i];
      hi_tab[int'(dig_codes[i])] = s_dhi[i];
      key_codes.push_back(int'(dig_codes[i]));
    end
    for (int i = 0; i < 12; i++) begin
      lo_tab[int'(pun_codes[i])] = pun_lo[i];
      hi_tab[int'(pun_codes[i])] = pun_hi[i];
      key_codes.push_back(int'(pun_codes[i]));
    end
    for (int i = 0; i < 4; i++) begin
      lo_tab[int'(ctl_codes[i])] = ctl_vals[i];
      hi_tab[int'(ctl_codes[i])] = ctl_vals[i];
      key_codes.push_back(int'(ctl_codes[i]));
    end
    key_codes.push_back(32'h05);
    ext_tab[32'h75] = 8'h80; ext_tab[32'h72] = 8'h81; ext_tab[32'h6B] = 8'h82;
    ext_tab[32'h74] = 8'h83; ext_tab[32'h5A] = 8'h0D; ext_tab[32'h4A] = 8'h2F;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    int n;
    #1;
    do_reset();

    // Plain make/break with output held to observe the entry latency.
    rdy_mode = 0;
    base = got_q.size();
    send(8'h1C); send(8'hF0); send(8'h1C);
    n = 0;
    while (up_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!key_valid && n < 6) begin @(negedge clk); n++; end
    chk("t1_valid_latency", 32'(key_valid), 32'(1));
    rdy_mode = 1;
    wait_drain();
    chk("t1_count", 32'(got_q.size() - base), 32'(1));
    chk_got("t1", base, 8'h61, 1'b0);
    if (got_q.size() > base) chk("t1_mods", 32'(got_q[base].mods), 32'(0));

    base = got_q.size();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    wait_drain();
    chk("t2_count", 32'(got_q.size() - base), 32'(1));
    chk_got("t2", base, 8'h41, 1'b0);
    if (got_q.size() > base) chk("t2_mods", 32'(got_q[base].mods), 32'(4'b0010));
    chk("t2_mods_after", 32'(dut_mods), 32'(0));

    base = got_q.size();
    tap(8'h58, 0); tap(8'h1C, 0);
    send(8'h12); tap(8'h1C, 0); send(8'hF0); send(8'h12);
    tap(8'h58, 0);
    wait_drain();
    chk("t3_count", 32'(got_q.size() - base), 32'(2));
    chk_got("t3a", base, 8'h41, 1'b0);
    chk_got("t3b", base + 1, 8'h61, 1'b0);
    chk("t3_mods_after", 32'(dut_mods), 32'(0));

    base = got_q.size();
    tap(8'h75, 1);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    tap(8'h16, 0);
    wait_drain();
    chk("t4_count", 32'(got_q.size() - base), 32'(2));
    chk_got("t4a", base, 8'h80, 1'b1);
    chk_got("t4b", base + 1, 8'h31, 1'b0);

    // Fill the output FIFO past capacity, then free one slot.
    rdy_mode = 0;
    base = got_q.size();
    repeat (8) send(8'h1C);
    wait_up();
    chk("t5_overflow_set", 32'(key_overflow), 32'(m_ovf));
    chk("t5_valid_full", 32'(key_valid), 32'(1));
    pop_budget = 1;
    repeat (3) @(negedge clk);
    chk("t5_overflow_clr", 32'(key_overflow), 32'(m_ovf));
    chk("t5_one_pop", 32'(got_q.size() - base), 32'(1));
    base = got_q.size();
    rdy_mode = 1;
    send(8'hF0); send(8'h1C);
    wait_drain();
    chk("t5_remaining", 32'(got_q.size() - base), 32'(6));

    // Reset after a lone E0 must forget the prefix.
    send(8'hE0);
    wait_up();
    do_reset();
    base = got_q.size();
    tap(8'h5A, 0);
    wait_drain();
    chk("t6_count", 32'(got_q.size() - base), 32'(1));
    chk_got("t6", base, 8'h0D, 1'b0);

    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      rand_event();
      if (i % 10 == 9) wait_drain();
    end
    wait_drain();
    chk("rand_mods_live", 32'(dut_mods), 32'(model_mods()));
    chk("rand_no_overflow", 32'(key_overflow), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
